mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- CPU-side initiator for the byte/half-word/word data memory.
- Takes one load/store request per handshake from the execute stage and checks alignment and range.
- Drives the memory's Addr/Data_input/Mode/ld/str/sel strobes for exactly one cycle, then returns sign- or zero-extended load data with a done pulse.
- The memory returns load data already right-justified and zero-filled, registered on the access edge.

Parameters:
- ADDR_WIDTH, 5: memory byte-address width; words in memory = 2**(ADDR_WIDTH-2).

Ports:
- clk  in  1  single clock, rising edge.
- clr_n  in  1  reset, asynchronous, active-low.
- req  in  1  request valid; accepted on a rising edge when ready=1.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 half-word, 10 word, 11 illegal.
- uns  in  1  load only: 1 = zero-extend, 0 = sign-extend.
- addr  in  32  byte address.
- wdata  in  32  store data, right-justified.
- ready  out  1  unit idle, can accept req.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: 1 = request faulted, no memory access made.
- rdata  out  32  extended load data; valid with done for non-faulting loads, held until the next load completes.
- mem_addr  out  ADDR_WIDTH  to memory Addr.
- mem_din  out  32  to memory Data_input.
- mem_mode  out  2  to memory Mode.
- mem_ld  out  1  load strobe.
- mem_str  out  1  store strobe.
- mem_sel  out  1  memory select.
- mem_dout  in  32  memory Data_output.

Behaviour:
- Reset (clr_n=0, async): state IDLE; done=0, err=0, rdata=0; all mem_* strobes 0 immediately. mem_addr, mem_din and mem_mode are 0.
- States: IDLE, ACCESS, CAPTURE, FAULT. ready=1 only in IDLE.
- IDLE: on edge with req=1, register we/size/uns/addr/wdata.
  - Go to FAULT if any of: size=11; size=01 and addr[0]=1; size=10 and addr[1:0]!=00; addr[31:ADDR_WIDTH]!=0.
  - Otherwise go to ACCESS.
- ACCESS (exactly 1 cycle): mem_sel=1, mem_mode=size, mem_addr=addr[ADDR_WIDTH-1:0], mem_din=wdata, mem_ld=~we, mem_str=we. The memory acts on the edge leaving ACCESS.
  - Store: go to IDLE; done<=1, err<=0 on that edge.
  - Load: go to CAPTURE.
- CAPTURE: go to IDLE; on that edge rdata<=extend(mem_dout), done<=1, err<=0.
- FAULT: go to IDLE; done<=1, err<=1 on that edge; rdata unchanged.
- Strobes are decoded from state only, so they are never asserted outside ACCESS.
- Latency in edges after the accept edge E0: store done after E1; load done after E2; fault done after E1.
- done is high for exactly 1 cycle. The unit is back in IDLE during that cycle, so a req in that cycle is accepted (back-to-back, no bubble).
- extend:
  - byte: bit7 replicated into [31:8] unless uns.
  - half: bit15 replicated into [31:16] unless uns.
  - word: passthrough; uns ignored.
- req while not ready is ignored; no queueing. The requester holds req until ready.
- Reset mid-ACCESS drops strobes asynchronously. A partial write to memory is not retried. No done is issued for the aborted request.

Decomposition:
- Shared package mem_pkg:
  - MODE_BYTE=2'b00, MODE_HALF=2'b01, MODE_WORD=2'b10, MODE_ILLEGAL=2'b11 (shared with the memory block).
  - State enum encoding.
  - Alignment-check function.
- Sub-module load_extend: combinational; inputs mem_dout, size, uns; output 32-bit extended data.

Test Plan:
- Store then load word: SW addr=0x8 wdata=0xDEADBEEF, then LW 0x8 -> SW done after E1 with mem_str=1, mem_mode=10 in ACCESS only; LW done after E2 with rdata=0xDEADBEEF, err=0.
- Byte sign/zero extension: memory word 0x0000_0080 at 0x4; LB 0x4 -> rdata=0xFFFFFF80; LBU 0x4 -> rdata=0x00000080.
- Half-word upper half, signed load: memory word 0x8001_1234 at 0xC; LH 0xE -> rdata=0xFFFF8001; LH 0xC -> rdata=0x00001234.
- Faults: LW 0x6, LH 0x3, size=11, and addr=0x20 with ADDR_WIDTH=5 -> each gives done+err=1 after E1; mem_sel/mem_ld/mem_str never assert; rdata keeps its previous value.
- Back-to-back: req held high with SB 0x1 (wdata 0xAB) followed by LBU 0x1 -> second request accepted in the done cycle of the first; LBU rdata=0x000000AB.
- Reset mid-op: clr_n low during LW ACCESS -> strobes and ready drop the same cycle; after release ready=1, done=0, rdata=0, and no stray done pulse.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access path.
// - MODE_* : access-size encoding, common to the unit and the memory block.
// - mau_state_e : FSM encoding of mem_access_unit.
// - misaligned() : alignment check for a size / low-address pair.
package mem_pkg;

  localparam logic [1:0] MODE_BYTE    = 2'b00;
  localparam logic [1:0] MODE_HALF    = 2'b01;
  localparam logic [1:0] MODE_WORD    = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FAULT   = 2'd3
  } mau_state_e;

  // An illegal size counts as misaligned, so one check covers both faults.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      MODE_BYTE: misaligned = 1'b0;
      MODE_HALF: misaligned = addr_lo[0];
      MODE_WORD: misaligned = (addr_lo != 2'b00);
      default:   misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Combinational sign/zero extension of right-justified load data.
// Ports:
//   mem_dout  in  32  memory data, right-justified and zero-filled
//   size      in  2   access size (MODE_*)
//   uns       in  1   1 = zero-extend, 0 = sign-extend (ignored for words)
//   ext_data  out 32  extended result
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] mem_dout,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] ext_data
);

  always_comb begin
    ext_data = mem_dout;
    case (size)
      MODE_BYTE: ext_data = {{24{~uns & mem_dout[7]}},  mem_dout[7:0]};
      MODE_HALF: ext_data = {{16{~uns & mem_dout[15]}}, mem_dout[15:0]};
      default:   ext_data = mem_dout;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side initiator for the byte/half/word data memory. Accepts one
// load/store per handshake, faults misaligned, illegal-size or out-of-range
// requests, drives the memory strobes for exactly one cycle and returns
// extended load data with a done pulse.
// Ports:
//   clk, clr_n             clock (rising edge), async active-low reset
//   req/we/size/uns/addr/wdata   request from the execute stage
//   ready                  unit idle (and out of reset), request can be taken
//   done/err/rdata         completion pulse, fault flag, extended load data
//   mem_addr/mem_din/mem_mode/mem_ld/mem_str/mem_sel   memory strobes
//   mem_dout               memory read data
//   fsm_state              current FSM state, for observation
//
// Handshake: a request transfers on a rising edge where req=1 and ready=1.
// The requester holds req and its fields stable until that edge; req while
// ready=0 is ignored. Exactly one done pulse follows each accepted request,
// and ready is high again during that pulse so the next request can be
// taken with no bubble.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  uns,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic                  ready,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  output logic [1:0]            mem_mode,
  output logic                  mem_ld,
  output logic                  mem_str,
  output logic                  mem_sel,
  input  logic [31:0]           mem_dout,
  output mau_state_e            fsm_state
);

  mau_state_e state, state_next;

  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_uns;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;

  logic [31:0] addr_hi;
  logic        fault_in;
  logic        accept;
  logic [31:0] ext_data;

  // Any address bit above the memory's byte range makes the request fault.
  assign addr_hi  = addr >> ADDR_WIDTH;
  assign fault_in = misaligned(size, addr[1:0]) || (addr_hi != 32'd0);
  assign accept   = req && (state == ST_IDLE);

  // State register
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (req) state_next = fault_in ? ST_FAULT : ST_ACCESS;
      ST_ACCESS:  state_next = r_we ? ST_IDLE : ST_CAPTURE;
      ST_CAPTURE: state_next = ST_IDLE;
      ST_FAULT:   state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state only; strobes can only be high in ACCESS.
  // ready is also gated by reset so nothing is taken while clr_n is low.
  always_comb begin
    ready    = clr_n && (state == ST_IDLE);
    mem_sel  = 1'b0;
    mem_ld   = 1'b0;
    mem_str  = 1'b0;
    mem_mode = 2'b00;
    mem_addr = '0;
    mem_din  = 32'd0;
    if (state == ST_ACCESS) begin
      mem_sel  = 1'b1;
      mem_ld   = ~r_we;
      mem_str  = r_we;
      mem_mode = r_size;
      mem_addr = r_addr;
      mem_din  = r_wdata;
    end
  end

  assign fsm_state = state;

  // Request capture
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_we    <= 1'b0;
      r_size  <= MODE_BYTE;
      r_uns   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
    end else if (accept) begin
      r_we    <= we;
      r_size  <= size;
      r_uns   <= uns;
      r_addr  <= addr[ADDR_WIDTH-1:0];
      r_wdata <= wdata;
    end
  end

  load_extend u_load_extend (
    .mem_dout (mem_dout),
    .size     (r_size),
    .uns      (r_uns),
    .ext_data (ext_data)
  );

  // Completion: stores finish leaving ACCESS, loads leaving CAPTURE (memory
  // data is registered on the ACCESS edge), faults leaving FAULT.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      done  <= 1'b0;
      err   <= 1'b0;
      rdata <= 32'd0;
    end else begin
      done <= ((state == ST_ACCESS) && r_we) || (state == ST_CAPTURE) || (state == ST_FAULT);
      err  <= (state == ST_FAULT);
      if (state == ST_CAPTURE) rdata <= ext_data;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          clr_n = 1'b0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [1:0]    size = 2'b00;
  logic          uns = 1'b0;
  logic [31:0]   addr = 32'd0;
  logic [31:0]   wdata = 32'd0;
  logic          ready, done, err;
  logic [31:0]   rdata;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic [1:0]    mem_mode;
  logic          mem_ld, mem_str, mem_sel;
  logic [31:0]   mem_dout = 32'd0;
  mau_state_e    fsm_state;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem_bytes [32] = '{default: 8'h00};

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .clr_n(clr_n), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err),
    .rdata(rdata), .mem_addr(mem_addr), .mem_din(mem_din), .mem_mode(mem_mode),
    .mem_ld(mem_ld), .mem_str(mem_str), .mem_sel(mem_sel), .mem_dout(mem_dout),
    .fsm_state(fsm_state)
  );

  // Little-endian byte memory; load data right-justified, zero-filled,
  // registered on the access edge.
  always @(posedge clk) begin
    if (mem_sel && mem_str) begin
      mem_bytes[mem_addr] <= mem_din[7:0];
      if (mem_mode != MODE_BYTE) mem_bytes[mem_addr + 5'd1] <= mem_din[15:8];
      if (mem_mode == MODE_WORD) begin
        mem_bytes[mem_addr + 5'd2] <= mem_din[23:16];
        mem_bytes[mem_addr + 5'd3] <= mem_din[31:24];
      end
    end
    if (mem_sel && mem_ld) begin
      case (mem_mode)
        MODE_BYTE: mem_dout <= {24'd0, mem_bytes[mem_addr]};
        MODE_HALF: mem_dout <= {16'd0, mem_bytes[mem_addr + 5'd1], mem_bytes[mem_addr]};
        default:   mem_dout <= {mem_bytes[mem_addr + 5'd3], mem_bytes[mem_addr + 5'd2],
                                mem_bytes[mem_addr + 5'd1], mem_bytes[mem_addr]};
      endcase
    end
  end

  // ---------------- driver ----------------
  // Issues one request and observes it until done. lat = edges after the
  // accept edge at which done was seen (-1 if it never came).
  task automatic run_req(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output int nsel, output int nld, output int nst,
                         output logic [1:0] mode_acc, output logic err_o, output logic [31:0] rdata_o);
    int waitc;
    lat = -1; nsel = 0; nld = 0; nst = 0; mode_acc = 2'b00; err_o = 1'bx; rdata_o = 'x;
    @(negedge clk);
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
    waitc = 0;
    while (!ready && waitc < 20) begin @(negedge clk); waitc++; end
    if (!ready) begin req = 1'b0; return; end
    @(posedge clk);
    #1 req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_sel) begin nsel++; mode_acc = mem_mode; end
      if (mem_ld) nld++;
      if (mem_str) nst++;
      if (done) begin lat = i; err_o = err; rdata_o = rdata; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clr_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata got %h exp 0", rdata); end
    checks++; if ({mem_sel, mem_ld, mem_str} !== 3'b000) begin errors++; $display("FAIL rst_strobes got %b exp 000", {mem_sel, mem_ld, mem_str}); end
    checks++; if ({mem_addr, mem_din, mem_mode} !== '0) begin errors++; $display("FAIL rst_membus got %h/%h/%b exp 0", mem_addr, mem_din, mem_mode); end
    clr_n = 1'b1;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b exp 1", ready); end
    checks++; if (fsm_state !== ST_IDLE) begin errors++; $display("FAIL rst_state got %0d exp 0", fsm_state); end
  endtask

  task automatic test_store_load_word();
    int lat, nsel, nld, nst; logic [1:0] m; logic e; logic [31:0] r;
    run_req(1'b1, MODE_WORD, 1'b0, 32'h8, 32'hDEADBEEF, lat, nsel, nld, nst, m, e, r);
    checks++; if (lat !== 1) begin errors++; $display("FAIL sw_lat got %0d exp 1", lat); end
    checks++; if (nsel !== 1 || nst !== 1 || nld !== 0) begin errors++; $display("FAIL sw_strobes got sel=%0d str=%0d ld=%0d exp 1 1 0", nsel, nst, nld); end
    checks++; if (m !== MODE_WORD) begin errors++; $display("FAIL sw_mode got %b exp 10", m); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL sw_err got %b exp 0", e); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL sw_done_width got %b exp 0", done); end
    run_req(1'b0, MODE_WORD, 1'b0, 32'h8, 32'h0, lat, nsel, nld, nst, m, e, r);
    checks++; if (lat !== 2) begin errors++; $display("FAIL lw_lat got %0d exp 2", lat); end
    checks++; if (nsel !== 1 || nld !== 1 || nst !== 0) begin errors++; $display("FAIL lw_strobes got sel=%0d ld=%0d str=%0d exp 1 1 0", nsel, nld, nst); end
    checks++; if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got %h exp deadbeef", r); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL lw_err got %b exp 0", e); end
  endtask

  task automatic test_byte_ext();
    int lat, nsel, nld, nst; logic [1:0] m; logic e; logic [31:0] r;
    run_req(1'b1, MODE_WORD, 1'b0, 32'h4, 32'h0000_0080, lat, nsel, nld, nst, m, e, r);
    checks++; if (lat !== 1) begin errors++; $display("FAIL sw4_lat got %0d exp 1", lat); end
    run_req(1'b0, MODE_BYTE, 1'b0, 32'h4, 32'h0, lat, nsel, nld, nst, m, e, r);
    checks++; if (r !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata got %h exp ffffff80", r); end
    checks++; if (m !== MODE_BYTE) begin errors++; $display("FAIL lb_mode got %b exp 00", m); end
    run_req(1'b0, MODE_BYTE, 1'b1, 32'h4, 32'h0, lat, nsel, nld, nst, m, e, r);
    checks++; if (r !== 32'h00000080) begin errors++; $display("FAIL lbu_rdata got %h exp 00000080", r); end
  endtask

  task automatic test_half_ext();
    int lat, nsel, nld, nst; logic [1:0] m; logic e; logic [31:0] r;
    run_req(1'b1, MODE_WORD, 1'b0, 32'hC, 32'h8001_1234, lat, nsel, nld, nst, m, e, r);
    run_req(1'b0, MODE_HALF, 1'b0, 32'hE, 32'h0, lat, nsel, nld, nst, m, e, r);
    checks++; if (r !== 32'hFFFF8001) begin errors++; $display("FAIL lh_hi_rdata got %h exp ffff8001", r); end
    checks++; if (m !== MODE_HALF) begin errors++; $display("FAIL lh_mode got %b exp 01", m); end
    run_req(1'b0, MODE_HALF, 1'b0, 32'hC, 32'h0, lat, nsel, nld, nst, m, e, r);
    checks++; if (r !== 32'h00001234) begin errors++; $display("FAIL lh_lo_rdata got %h exp 00001234", r); end
  endtask

  task automatic test_faults();
    int lat, nsel, nld, nst; logic [1:0] m; logic e; logic [31:0] r;
    logic [1:0]  f_size [4] = '{MODE_WORD, MODE_HALF, MODE_ILLEGAL, MODE_WORD};
    logic [31:0] f_addr [4] = '{32'h6, 32'h3, 32'h0, 32'h20};
    // rdata still holds 0x1234 from the last half-word load
    for (int k = 0; k < 4; k++) begin
      run_req(1'b0, f_size[k], 1'b0, f_addr[k], 32'h0, lat, nsel, nld, nst, m, e, r);
      checks++; if (lat !== 1) begin errors++; $display("FAIL fault%0d_lat got %0d exp 1", k, lat); end
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL fault%0d_err got %b exp 1", k, e); end
      checks++; if (nsel + nld + nst !== 0) begin errors++; $display("FAIL fault%0d_strobes got %0d exp 0", k, nsel + nld + nst); end
      checks++; if (r !== 32'h00001234) begin errors++; $display("FAIL fault%0d_rdata got %h exp 00001234", k, r); end
    end
    // a store that faults must not reach memory either
    run_req(1'b1, MODE_HALF, 1'b0, 32'h9, 32'hFFFF, lat, nsel, nld, nst, m, e, r);
    checks++; if (e !== 1'b1 || nst !== 0) begin errors++; $display("FAIL fault_st got err=%b str=%0d exp 1 0", e, nst); end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = MODE_BYTE; uns = 1'b0; addr = 32'h1; wdata = 32'hAB;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0 got %b exp 1", ready); end
    @(negedge clk);
    checks++; if (mem_str !== 1'b1) begin errors++; $display("FAIL b2b_sb_str got %b exp 1", mem_str); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || ready !== 1'b1) begin errors++; $display("FAIL b2b_sb_done got done=%b ready=%b exp 1 1", done, ready); end
    we = 1'b0; uns = 1'b1; size = MODE_BYTE; addr = 32'h1;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    checks++; if (mem_ld !== 1'b1) begin errors++; $display("FAIL b2b_lbu_accept got ld=%b exp 1", mem_ld); end
    lat = -1;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      if (done) begin lat = i; break; end
    end
    checks++; if (lat !== 2) begin errors++; $display("FAIL b2b_lbu_lat got %0d exp 2", lat); end
    checks++; if (rdata !== 32'h000000AB) begin errors++; $display("FAIL b2b_lbu_rdata got %h exp 000000ab", rdata); end
  endtask

  task automatic test_reset_midop();
    int ndone;
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = MODE_WORD; uns = 1'b0; addr = 32'h8;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    checks++; if (mem_ld !== 1'b1) begin errors++; $display("FAIL rmid_access got ld=%b exp 1", mem_ld); end
    #1 clr_n = 1'b0;
    #1;
    checks++; if ({mem_sel, mem_ld, mem_str, ready} !== 4'b0000) begin errors++; $display("FAIL rmid_drop got %b exp 0000", {mem_sel, mem_ld, mem_str, ready}); end
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    #1;
    checks++; if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL rmid_release got ready=%b done=%b exp 1 0", ready, done); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL rmid_rdata got %h exp 0", rdata); end
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL rmid_stray_done got %0d exp 0", ndone); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_store_load_word();
    test_byte_ext();
    test_half_ext();
    test_faults();
    test_back_to_back();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
